// File: rtl/opc2_pkg.sv
// Shared definitions for the OPC2 memory responder: I/O page map, STATUS bit
// positions and the OPC2 opcode set used when assembling test programs.
package opc2_pkg;

    // I/O page base and register offsets within it
    localparam logic [10:0] IO_BASE      = 11'h7F0;
    localparam logic [3:0]  OFF_TXDATA   = 4'h8;
    localparam logic [3:0]  OFF_STATUS   = 4'h9;
    localparam logic [3:0]  OFF_TIMER    = 4'hA;
    localparam logic [3:0]  OFF_PORT_OUT = 4'hB;
    localparam logic [3:0]  OFF_PORT_IN  = 4'hC;

    // STATUS register bit positions
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_TMR_OVF  = 2;
    localparam int unsigned ST_TX_OVR   = 3;
    localparam int unsigned ST_WP_VIOL  = 4;

    // OPC2 opcode field values
    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_LDA  = 4'h1,
        OP_NOT  = 4'h2,
        OP_ADD  = 4'h3,
        OP_JPC  = 4'h4,
        OP_JPZ  = 4'h5,
        OP_STA  = 4'h6,
        OP_JAL  = 4'h7,
        OP_LDAP = 4'h8,
        OP_STAP = 4'h9,
        OP_HALT = 4'hF
    } opc2_op_e;

endpackage

// File: rtl/opc2_txfifo.sv
// Register-based transmit FIFO. DEPTH must be a power of two (>= 2) so the
// read/write pointers wrap naturally. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module opc2_txfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_CNT);
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on accepted push, contents need no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/opc2_mem_responder.sv
// OPC2 bus slave: byte RAM at 0x000-0x7EF plus an I/O page at 0x7F0-0x7FF
// (TX FIFO, prescaled timer, output port, synchronised input port).
// Reads are combinational; writes commit on the rising edge when rnw=0.
// Optional build macro OPC2_WRITE_PROTECT_EN blocks writes to WP_LO..WP_HI
// and records the attempt in STATUS.wp_viol.
module opc2_mem_responder
    import opc2_pkg::*;
#(
    parameter int unsigned TXF_DEPTH = 4,
    parameter int unsigned PRESCALE  = 256,
    parameter logic [10:0] WP_LO     = 11'h100,
    parameter logic [10:0] WP_HI     = 11'h3FF,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [10:0] address,
    inout  wire  [7:0]  data,
    input  logic        rnw,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  port_out,
    input  logic [7:0]  port_in
);
    localparam int unsigned RAM_WORDS = 32'h7F0;
    localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [7:0]  r_ram [RAM_WORDS];
    logic [7:0]  r_timer;
    logic [PW-1:0] r_presc;
    logic        r_tmr_ovf;
    logic        r_tx_ovr;
    logic [7:0]  r_port_out;
    logic [7:0]  r_pin_s1;
    logic [7:0]  r_pin_s2;

    logic        w_io;
    logic [3:0]  w_off;
    logic        w_wr;
    logic        w_wr_tx;
    logic        w_wr_status;
    logic        w_wr_timer;
    logic        w_wr_port;
    logic        w_wp_hit;
    logic        w_wp_viol_bit;
    logic        w_tick;
    logic        w_tmr_ovf_set;
    logic        w_tx_ovr_set;
    logic        w_pop;
    logic        w_txf_full;
    logic        w_txf_empty;
    logic [$clog2(TXF_DEPTH):0] w_unused_txf_count;
    logic [7:0]  w_status;
    logic [7:0]  w_rd_data;

    assign w_io        = (address >= IO_BASE);
    assign w_off       = address[3:0];
    assign w_wr        = !rnw;
    assign w_wr_tx     = w_wr && w_io && (w_off == OFF_TXDATA);
    assign w_wr_status = w_wr && w_io && (w_off == OFF_STATUS);
    assign w_wr_timer  = w_wr && w_io && (w_off == OFF_TIMER);
    assign w_wr_port   = w_wr && w_io && (w_off == OFF_PORT_OUT);

`ifdef OPC2_WRITE_PROTECT_EN
    logic r_wp_viol;
    assign w_wp_hit      = (address >= WP_LO) && (address <= WP_HI);
    assign w_wp_viol_bit = r_wp_viol;

    // Sticky write-protect violation flag; a new violation beats a W1C clear
    always_ff @(posedge clk) begin
        if (!reset_b) r_wp_viol <= 1'b0;
        else          r_wp_viol <= (w_wr && w_wp_hit) |
                                   (r_wp_viol & ~(w_wr_status & data[ST_WP_VIOL]));
    end
`else
    logic [21:0] w_unused_wp;
    assign w_unused_wp   = {WP_LO, WP_HI};
    assign w_wp_hit      = 1'b0;
    assign w_wp_viol_bit = 1'b0;
`endif

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (reset_b && w_wr && !w_io && !w_wp_hit) begin
            r_ram[address] <= data;
        end
    end

    assign tx_valid = !w_txf_empty;
    assign w_pop    = tx_valid && tx_ready;

    opc2_txfifo #(.DEPTH(TXF_DEPTH)) u_txfifo (
        .clk       (clk),
        .reset_b   (reset_b),
        .push      (w_wr_tx),
        .push_data (data),
        .pop       (w_pop),
        .head      (tx_data),
        .count     (w_unused_txf_count),
        .full      (w_txf_full),
        .empty     (w_txf_empty)
    );

    assign w_tick        = (r_presc == PW'(PRESCALE - 1));
    assign w_tmr_ovf_set = w_tick && !w_wr_timer && (r_timer == 8'hFF);
    assign w_tx_ovr_set  = w_wr_tx && w_txf_full && !w_pop;

    // Prescaler and timer; a CPU load in a tick cycle takes precedence
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_presc <= '0;
            r_timer <= '0;
        end else if (w_wr_timer) begin
            r_presc <= '0;
            r_timer <= data;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) r_timer <= r_timer + 8'd1;
        end
    end

    // Sticky status flags with write-one-to-clear; set beats clear
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_tmr_ovf <= 1'b0;
            r_tx_ovr  <= 1'b0;
        end else begin
            r_tmr_ovf <= w_tmr_ovf_set | (r_tmr_ovf & ~(w_wr_status & data[ST_TMR_OVF]));
            r_tx_ovr  <= w_tx_ovr_set  | (r_tx_ovr  & ~(w_wr_status & data[ST_TX_OVR]));
        end
    end

    // Output port register and two-flop input synchroniser
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_port_out <= '0;
            r_pin_s1   <= '0;
            r_pin_s2   <= '0;
        end else begin
            r_pin_s1 <= port_in;
            r_pin_s2 <= r_pin_s1;
            if (w_wr_port) r_port_out <= data;
        end
    end

    assign port_out = r_port_out;
    assign w_status = {3'b000, w_wp_viol_bit, r_tx_ovr, r_tmr_ovf, w_txf_empty, w_txf_full};

    // Side-effect-free read decode
    always_comb begin
        w_rd_data = '0;
        if (!w_io) begin
            w_rd_data = r_ram[address];
        end else begin
            case (w_off)
                OFF_STATUS:   w_rd_data = w_status;
                OFF_TIMER:    w_rd_data = r_timer;
                OFF_PORT_OUT: w_rd_data = r_port_out;
                OFF_PORT_IN:  w_rd_data = r_pin_s2;
                default:      w_rd_data = '0;
            endcase
        end
    end

    assign data = rnw ? w_rd_data : 8'hzz;

endmodule

// File: tb/tb_opc2_mem_responder.sv
// Self-checking bench for opc2_mem_responder (PRESCALE=4, TXF_DEPTH=4).
// Expected read data and FIFO output are queued when stimulus is applied and
// popped when the DUT presents the result.
`timescale 1ns/1ps
module tb_opc2_mem_responder;
    import opc2_pkg::*;

    localparam logic [10:0] A_IDLE   = IO_BASE;
    localparam logic [10:0] A_TXDATA = IO_BASE | {7'b0, OFF_TXDATA};
    localparam logic [10:0] A_STATUS = IO_BASE | {7'b0, OFF_STATUS};
    localparam logic [10:0] A_TIMER  = IO_BASE | {7'b0, OFF_TIMER};
    localparam logic [10:0] A_PORTO  = IO_BASE | {7'b0, OFF_PORT_OUT};
    localparam logic [10:0] A_PORTI  = IO_BASE | {7'b0, OFF_PORT_IN};
    localparam int unsigned DEPTH    = 4;
`ifdef OPC2_WRITE_PROTECT_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_b;
    logic [10:0] address;
    logic        rnw;
    logic [7:0]  drv;
    logic        drv_en;
    wire  [7:0]  data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  port_out;
    logic [7:0]  port_in;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  tx_q[$];
    logic        m_ovr = 1'b0;

    assign data = drv_en ? drv : 8'hzz;
    always #5 clk = ~clk;

    opc2_mem_responder #(.TXF_DEPTH(DEPTH), .PRESCALE(4)) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .address  (address),
        .data     (data),
        .rnw      (rnw),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .port_out (port_out),
        .port_in  (port_in)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_status(input logic ovf, input logic ovr, input logic wp);
        return {3'b000, wp, ovr, ovf, tx_q.size() == 0, tx_q.size() == DEPTH};
    endfunction

    task automatic idle();
        rnw = 1'b1; drv_en = 1'b0; address = A_IDLE;
    endtask

    task automatic wr(input logic [10:0] a, input logic [7:0] v);
        @(negedge clk);
        address = a; rnw = 1'b0; drv = v; drv_en = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd_check(input string tag, input logic [10:0] a, input logic [7:0] exp);
        @(negedge clk);
        address = a; rnw = 1'b1; drv_en = 1'b0;
        sb_q.push_back(exp);
        #2;
        check(tag, data, sb_q.pop_front());
    endtask

    // TXDATA write with the FIFO model updated the way the sink sees it
    task automatic push_tx(input logic [7:0] v);
        @(negedge clk);
        address = A_TXDATA; rnw = 1'b0; drv = v; drv_en = 1'b1;
        #2;
        if (tx_ready && tx_q.size() > 0) check("tx_data_pp", tx_data, tx_q.pop_front());
        if (tx_q.size() < DEPTH) tx_q.push_back(v);
        else m_ovr = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        tx_ready = 1'b1;
        #2;
        for (int i = 0; i < 8 && tx_q.size() > 0; i++) begin
            check({tag, "_valid"}, {7'b0, tx_valid}, 8'h01);
            check({tag, "_data"}, tx_data, tx_q.pop_front());
            @(negedge clk); #2;
        end
        check({tag, "_empty"}, {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        idle();
        drv = '0; tx_ready = 1'b0; port_in = '0; reset_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;

        // Reset state
        rd_check("rst_timer",  A_TIMER,  8'h00);
        rd_check("rst_status", A_STATUS, 8'h02);
        rd_check("rst_porto",  A_PORTO,  8'h00);
        check("rst_txvalid", {7'b0, tx_valid}, 8'h00);
        check("rst_txdata",  tx_data, 8'h00);

        // RAM read/write, including the last RAM byte
        wr(11'h010, 8'hA5);
        wr(11'h7EF, 8'h3C);
        rd_check("ram_010", 11'h010, 8'hA5);
        rd_check("ram_7ef", 11'h7EF, 8'h3C);

        // Bus must carry the CPU's value only while rnw=0
        @(negedge clk);
        address = 11'h010; rnw = 1'b0; drv = 8'h5A; drv_en = 1'b1;
        #2;
        check("bus_wr", data, 8'h5A);
        @(posedge clk); #1;
        idle();
        rd_check("ram_010_ow", 11'h010, 8'h5A);

        // Unused I/O and TXDATA read as zero
        wr(11'h7F3, 8'h55);
        rd_check("io_unused", 11'h7F3, 8'h00);
        rd_check("io_txdata", A_TXDATA, 8'h00);

        // Output port
        wr(A_PORTO, 8'hC3);
        rd_check("porto_rd", A_PORTO, 8'hC3);
        check("porto_pin", port_out, 8'hC3);

        // Input port: two edges of synchroniser latency
        @(negedge clk);
        port_in = 8'h96; address = A_PORTI;
        #2; check("porti_0", data, 8'h00);
        @(negedge clk); #2; check("porti_1", data, 8'h00);
        @(negedge clk); #2; check("porti_2", data, 8'h96);

        // FIFO fill with overflow
        foreach (tx_q[i]) tx_q.delete(i);
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44); push_tx(8'h55);
        rd_check("st_full_ovr", A_STATUS, exp_status(1'b0, m_ovr, 1'b0));
        @(negedge clk); #2; check("tx_hold0", tx_data, 8'h11);
        @(negedge clk); #2; check("tx_hold1", tx_data, 8'h11);
        drain("drain1");
        wr(A_STATUS, 8'h08);
        m_ovr = 1'b0;
        rd_check("st_ovr_clr", A_STATUS, exp_status(1'b0, m_ovr, 1'b0));

        // Push while full and popping: accepted, no overflow
        push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3); push_tx(8'hA4);
        tx_ready = 1'b1;
        push_tx(8'h66);
        drain("drain2");
        rd_check("st_pp", A_STATUS, exp_status(1'b0, m_ovr, 1'b0));

        // Timer wrap 0xFE -> 0xFF -> 0x00 over eight cycles
        wr(A_TIMER, 8'hFE);
        repeat (8) @(posedge clk);
        rd_check("tmr_wrap", A_TIMER, 8'h00);
        rd_check("st_ovf", A_STATUS, exp_status(1'b1, 1'b0, 1'b0));
        wr(A_STATUS, 8'h04);
        rd_check("st_ovf_clr", A_STATUS, exp_status(1'b0, 1'b0, 1'b0));

        // Load on a tick cycle with timer at 0xFF: load wins, no overflow
        wr(A_TIMER, 8'hFF);
        repeat (3) @(posedge clk);
        wr(A_TIMER, 8'h5A);
        rd_check("tmr_ld_tick", A_TIMER, 8'h5A);
        rd_check("st_ld_tick", A_STATUS, exp_status(1'b0, 1'b0, 1'b0));

        // Write protect window and its edges
        wr(11'h150, 8'h77);
        @(negedge clk);
        address = 11'h150; #2;
        check("wp_150", {7'b0, data === 8'h77}, {7'b0, ~WP_ON});
        rd_check("st_wp", A_STATUS, exp_status(1'b0, 1'b0, WP_ON));
        wr(11'h0FF, 8'h5C);
        rd_check("wp_below", 11'h0FF, 8'h5C);
        wr(11'h400, 8'hC5);
        rd_check("wp_above", 11'h400, 8'hC5);
        wr(A_STATUS, 8'h10);
        rd_check("st_wp_clr", A_STATUS, exp_status(1'b0, 1'b0, 1'b0));

        // Reset mid-operation drops queued bytes and clears registers
        push_tx(8'hE1); push_tx(8'hE2);
        @(negedge clk);
        reset_b = 1'b0;
        tx_q.delete();
        @(negedge clk); #2;
        check("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
        check("mid_rst_porto", port_out, 8'h00);
        reset_b = 1'b1;
        rd_check("mid_rst_timer", A_TIMER, 8'h00);
        rd_check("mid_rst_status", A_STATUS, exp_status(1'b0, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
